// File: rtl/serializer_pkg.sv
// Shared types and helpers for the bit_serializer front end and the detector bench.
package serializer_pkg;

    localparam int WIDTH = 46;

    typedef enum logic {IDLE, SHIFT} state_t;

    function automatic int unsigned len_clamp(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/word_buffer.sv
// Single-entry pending word register: load fills it, take empties it.
module word_buffer #(
    parameter int WIDTH = 46,
    parameter int LW    = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LW-1:0]    load_len,
    input  logic             take,
    output logic [WIDTH-1:0] data,
    output logic [LW-1:0]    len,
    output logic             full
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
            len  <= '0;
            full <= 1'b0;
        end else if (load) begin
            data <= load_data;
            len  <= load_len;
            full <= 1'b1;
        end else if (take) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Variable-length parallel-to-serial front end, MSB-first, gap-free across words
// via a one-word pending buffer or a same-cycle bypass into the shifter.
module bit_serializer #(
    parameter int WIDTH = serializer_pkg::WIDTH,
    localparam int LW   = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LW-1:0]    in_len,
    input  logic             pause,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done
);
    import serializer_pkg::*;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [LW-1:0]    cnt, cnt_n;
    logic             w_n, w_valid_n, done_n;

    logic             pend_full, pend_load, pend_take;
    logic [WIDTH-1:0] pend_data;
    logic [LW-1:0]    pend_len;

    logic [LW-1:0]    acc_len;
    logic             accept, acc_nz, last;

    assign acc_len  = LW'(len_clamp(32'(in_len), WIDTH));
    assign in_ready = !pend_full;
    assign accept   = in_valid && in_ready;
    assign acc_nz   = accept && (acc_len != '0);
    assign last     = (state == SHIFT) && !pause && (cnt == LW'(1));

    word_buffer #(.WIDTH(WIDTH), .LW(LW)) u_pend (
        .clk       (clk),
        .rst       (rst),
        .load      (pend_load),
        .load_data (in_data),
        .load_len  (acc_len),
        .take      (pend_take),
        .data      (pend_data),
        .len       (pend_len),
        .full      (pend_full)
    );

    // cnt counts bits still to be placed on w after the current edge's emission.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        cnt_n     = cnt;
        w_n       = w;
        w_valid_n = 1'b0;
        done_n    = 1'b0;
        pend_load = 1'b0;
        pend_take = 1'b0;
        case (state)
            IDLE: begin
                if (acc_nz) begin
                    shreg_n = in_data;
                    cnt_n   = acc_len;
                    state_n = SHIFT;
                    // First bit goes out on the accepting edge to meet one-cycle latency.
                    if (!pause) begin
                        w_n       = in_data[acc_len - LW'(1)];
                        w_valid_n = 1'b1;
                        cnt_n     = acc_len - LW'(1);
                        done_n    = (acc_len == LW'(1));
                        if (acc_len == LW'(1))
                            state_n = IDLE;
                    end
                end
            end
            SHIFT: begin
                if (!pause) begin
                    w_n       = shreg[cnt - LW'(1)];
                    w_valid_n = 1'b1;
                    cnt_n     = cnt - LW'(1);
                end
                if (last) begin
                    done_n = 1'b1;
                    if (pend_full) begin
                        shreg_n   = pend_data;
                        cnt_n     = pend_len;
                        pend_take = 1'b1;
                    end else if (acc_nz) begin
                        shreg_n = in_data;
                        cnt_n   = acc_len;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (acc_nz) begin
                    pend_load = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            w       <= 1'b0;
            w_valid <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            cnt     <= cnt_n;
            w       <= w_n;
            w_valid <= w_valid_n;
            done    <= done_n;
            busy    <= (state_n == SHIFT) || w_valid_n;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: scoreboard of expected {bit,done} pairs drained by a monitor.
module tb_bit_serializer;
    import serializer_pkg::*;
    localparam int LW = $clog2(WIDTH+1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic [LW-1:0]    in_len = '0;
    logic             pause = 1'b0;
    logic             in_ready, w, w_valid, busy, done;

    int vectors = 0;
    int errors  = 0;
    int bits_seen = 0;
    logic [1:0] sbq[$];

    bit_serializer dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_len   (in_len),
        .pause    (pause),
        .w        (w),
        .w_valid  (w_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Every emitted bit must match the head of the scoreboard, in order.
    always @(negedge clk) begin
        if (rst && w_valid) begin
            bits_seen++;
            vectors++;
            assert (sbq.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_bit: observed w=%b done=%b, required no output", w, done);
            end
            if (sbq.size() > 0) begin
                logic [1:0] exp;
                exp = sbq.pop_front();
                assert ({w, done} === exp) else begin
                    errors++;
                    $error("FAIL serial_bit: observed {w,done}=%b, required %b", {w, done}, exp);
                end
            end
        end else if (rst) begin
            vectors++;
            assert (done === 1'b0) else begin
                errors++;
                $error("FAIL done_without_bit: observed done=%b, required 0", done);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d, input int len);
        int n;
        n = (len > WIDTH) ? WIDTH : len;
        for (int i = n - 1; i >= 0; i--)
            sbq.push_back({d[i], (i == 0) ? 1'b1 : 1'b0});
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input int len);
        in_valid = 1'b1;
        in_data  = d;
        in_len   = LW'(len);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || w_valid || sbq.size() != 0) && n < 500) begin
            step();
            n++;
        end
        chk("drain_timeout", (n < 500), 1);
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        int base;

        // Reset
        repeat (2) step();
        chk("rst_w", w, 0);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b1;
        repeat (3) step();
        chk("idle_w_valid", w_valid, 0);
        chk("idle_busy", busy, 0);

        // Single full-width word
        d = 46'b1101010011000010101101010011000000010011000011;
        base = bits_seen;
        push_word(d, 46);
        send(d, 46);
        chk("latency_w_valid", w_valid, 1);
        chk("latency_first_bit", w, d[45]);
        chk("latency_busy", busy, 1);
        wait_idle();
        chk("single_bit_count", bits_seen - base, 46);

        // Back-to-back through the pending buffer
        push_word(46'b101, 3);
        push_word(46'b01, 2);
        send(46'b101, 3);
        chk("b2b_c1_valid", w_valid, 1);
        in_valid = 1'b1; in_data = 46'b01; in_len = LW'(2);
        step();
        in_valid = 1'b0;
        chk("b2b_pending_ready", in_ready, 0);
        chk("b2b_c2_valid", w_valid, 1);
        step();
        chk("b2b_c3_valid", w_valid, 1);
        chk("b2b_c3_done", done, 1);
        chk("b2b_ready_after_take", in_ready, 1);
        step();
        chk("b2b_c4_valid", w_valid, 1);
        step();
        chk("b2b_c5_valid", w_valid, 1);
        chk("b2b_c5_done", done, 1);
        step();
        chk("b2b_end_valid", w_valid, 0);
        chk("b2b_end_busy", busy, 0);

        // Back-to-back through the bypass path (accept on the last-bit edge)
        push_word(46'b10, 2);
        push_word(46'b011, 3);
        send(46'b10, 2);
        send(46'b011, 3);
        chk("bypass_c2_valid", w_valid, 1);
        chk("bypass_c2_done", done, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bypass_gapless", w_valid, 1);
        end
        wait_idle();

        // Pause mid-word
        push_word(46'b1001, 4);
        send(46'b1001, 4);
        step();
        chk("pause_pre_w", w, 0);
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("pause_w_valid", w_valid, 0);
            chk("pause_w_held", w, 0);
            chk("pause_busy", busy, 1);
        end
        pause = 1'b0;
        step();
        chk("pause_resume_valid", w_valid, 1);
        wait_idle();

        // Zero length is dropped
        base = bits_seen;
        send('1, 0);
        chk("len0_ready", in_ready, 1);
        chk("len0_w_valid", w_valid, 0);
        chk("len0_busy", busy, 0);
        repeat (3) step();
        chk("len0_bit_count", bits_seen - base, 0);

        // Over-length is clamped to WIDTH
        d = {$urandom, $urandom};
        base = bits_seen;
        push_word(d, 63);
        send(d, 63);
        wait_idle();
        chk("len63_bit_count", bits_seen - base, 46);

        // Asynchronous reset mid-word with a pending word queued
        push_word(46'b1011001110, 10);
        push_word(46'b11111, 5);
        send(46'b1011001110, 10);
        send(46'b11111, 5);
        chk("mid_pending_ready", in_ready, 0);
        step();
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        sbq.delete();
        chk("arst_w", w, 0);
        chk("arst_w_valid", w_valid, 0);
        chk("arst_done", done, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        base = bits_seen;
        step();
        rst = 1'b1;
        repeat (20) step();
        chk("arst_no_trailing_bits", bits_seen - base, 0);
        chk("arst_idle_busy", busy, 0);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
